// File: rtl/fixed_addsub_sm_if.sv
// Operand/result bundle for fixed_addsub_sm: start handshake, operands,
// saturated sign-magnitude results and per-lane overflow flags.
// Optional macro FIXADD_ACC_EN adds the acc_en request bit.
interface fixed_addsub_sm_if #(
  parameter int W     = 16,
  parameter int LANES = 2
);
  logic               cs_add;
  logic               op_sub;
  logic [LANES*W-1:0] x;
  logic [LANES*W-1:0] y;
  logic [LANES*W-1:0] sum;
  logic [LANES-1:0]   ovf;
  logic               rdy_add;
  logic               done;
`ifdef FIXADD_ACC_EN
  logic               acc_en;
`endif

  modport master (
`ifdef FIXADD_ACC_EN
    output acc_en,
`endif
    output cs_add, op_sub, x, y,
    input  sum, ovf, rdy_add, done
  );

  modport slave (
`ifdef FIXADD_ACC_EN
    input  acc_en,
`endif
    input  cs_add, op_sub, x, y,
    output sum, ovf, rdy_add, done
  );
endinterface

// File: rtl/fixed_addsub_sm.sv
// Multi-lane saturating sign-magnitude adder/subtractor with a 3-cycle
// IDLE -> CONV -> SUM operation. Lanes are fully independent.
// Optional macro FIXADD_ACC_EN: acc_en selects the lane's own sum register
// as the second operand, turning each lane into a saturating accumulator.
module fixed_addsub_sm #(
  parameter int W     = 16,
  parameter int LANES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  fixed_addsub_sm_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, CONV, SUM} state_t;

  localparam logic signed [W:0] MAX_POS = (W+1)'((1 << (W-1)) - 1);
  localparam logic signed [W:0] MAX_NEG = -MAX_POS;

  state_t state_q, state_d;

  logic [LANES*W-1:0]     x_q, x_d;
  logic [LANES*W-1:0]     y_q, y_d;
  logic                   op_sub_q, op_sub_d;
  logic [LANES*(W+1)-1:0] a_q, a_d;
  logic [LANES*(W+1)-1:0] b_q, b_d;
  logic [LANES*W-1:0]     sum_q, sum_d;
  logic [LANES-1:0]       ovf_q, ovf_d;
  logic                   done_q, done_d;
`ifdef FIXADD_ACC_EN
  logic                   acc_en_q, acc_en_d;
`endif

  logic [W-1:0]      opnd_c;
  logic signed [W:0] tot_c;

  // Sign-magnitude to (W+1)-bit two's complement; negative zero maps to 0.
  function automatic logic [W:0] to_tc(input logic [W-1:0] v);
    logic [W:0] m;
    m = {2'b00, v[W-2:0]};
    return v[W-1] ? -m : m;
  endfunction

  // In-range two's complement back to sign-magnitude; zero is always +0.
  function automatic logic [W-1:0] to_sm(input logic signed [W:0] t);
    return {t[W], (W-1)'(t[W] ? -t : t)};
  endfunction

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: accept only in IDLE, then walk CONV and SUM unconditionally.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.cs_add) state_d = CONV;
      CONV:    state_d = SUM;
      SUM:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: ready whenever idle; results come straight from their registers.
  always_comb begin
    bus.rdy_add = (state_q == IDLE);
    bus.done    = done_q;
    bus.sum     = sum_q;
    bus.ovf     = ovf_q;
  end

  // Datapath registers; reset clears everything and aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      op_sub_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      ovf_q    <= '0;
      done_q   <= 1'b0;
`ifdef FIXADD_ACC_EN
      acc_en_q <= 1'b0;
`endif
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      op_sub_q <= op_sub_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
`ifdef FIXADD_ACC_EN
      acc_en_q <= acc_en_d;
`endif
    end
  end

  // Per-state datapath: capture, convert to two's complement, add and saturate.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    op_sub_d = op_sub_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
`ifdef FIXADD_ACC_EN
    acc_en_d = acc_en_q;
`endif
    opnd_c   = '0;
    tot_c    = '0;
    case (state_q)
      IDLE: begin
        if (bus.cs_add) begin
          x_d      = bus.x;
          y_d      = bus.y;
          op_sub_d = bus.op_sub;
`ifdef FIXADD_ACC_EN
          acc_en_d = bus.acc_en;
`endif
        end
      end
      CONV: begin
        for (int i = 0; i < LANES; i++) begin
          opnd_c = y_q[i*W +: W];
`ifdef FIXADD_ACC_EN
          if (acc_en_q) opnd_c = sum_q[i*W +: W];
`endif
          if (op_sub_q) opnd_c[W-1] = ~opnd_c[W-1];
          a_d[i*(W+1) +: (W+1)] = to_tc(x_q[i*W +: W]);
          b_d[i*(W+1) +: (W+1)] = to_tc(opnd_c);
        end
      end
      SUM: begin
        for (int i = 0; i < LANES; i++) begin
          tot_c = signed'(a_q[i*(W+1) +: (W+1)]) + signed'(b_q[i*(W+1) +: (W+1)]);
          if (tot_c > MAX_POS) begin
            sum_d[i*W +: W] = {1'b0, {(W-1){1'b1}}};
            ovf_d[i]        = 1'b1;
          end else if (tot_c < MAX_NEG) begin
            sum_d[i*W +: W] = {W{1'b1}};
            ovf_d[i]        = 1'b1;
          end else begin
            sum_d[i*W +: W] = to_sm(tot_c);
            ovf_d[i]        = 1'b0;
          end
        end
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
